// File: rtl/rom_text_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_text_loader
//  Purpose  : Byte-stream program loader. Receives a framed image
//             (MAGIC, CNT_LO, CNT_HI, N*4 data bytes, XOR CSUM) and writes it
//             word by word into the instruction BRAM write port. Holds the
//             CPU stalled until a load completes with a good checksum.
//  Revision : 1.0  initial release
// ============================================================================
module rom_text_loader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic                  rawclk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  // Largest legal word count: exactly fills the memory.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                state;
  state_t                state_next;
  logic [7:0]            cnt_lo;
  logic [15:0]           word_cnt;
  logic [ADDR_WIDTH:0]   word_idx;   // one bit wider so N = depth is representable
  logic [1:0]            lane;
  logic [23:0]           shreg;      // first three bytes of the current word
  logic [7:0]            xor_acc;

  logic                  accept;
  logic [15:0]           len_n;
  logic                  len_too_big;
  logic [16:0]           idx_next;
  logic                  last_word;

  assign accept      = in_valid && in_ready;
  assign len_n       = {in_data, cnt_lo};
  assign len_too_big = {1'b0, len_n} > MAX_WORDS;
  assign idx_next    = 17'(word_idx) + 17'd1;
  assign last_word   = (idx_next == {1'b0, word_cnt});

  // State register.
  always_ff @(posedge rawclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived status outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept && (in_data == MAGIC)) state_next = LEN0;
      end
      LEN0: begin
        in_ready = 1'b1;
        if (accept) state_next = LEN1;
      end
      LEN1: begin
        in_ready = 1'b1;
        if (accept) begin
          if (len_too_big)        state_next = ERR;
          else if (len_n == '0)   state_next = CSUM;
          else                    state_next = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (accept && (lane == 2'd3) && last_word) state_next = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (accept) state_next = (in_data == xor_acc) ? DONE : ERR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (reload) state_next = IDLE;
      end
      ERR: begin
        error = 1'b1;
        if (reload) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Length capture, byte assembly, checksum accumulation and BRAM write pulse.
  always_ff @(posedge rawclk) begin
    if (rst) begin
      cnt_lo   <= '0;
      word_cnt <= '0;
      word_idx <= '0;
      lane     <= '0;
      shreg    <= '0;
      xor_acc  <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        LEN0: begin
          if (accept) cnt_lo <= in_data;
        end
        LEN1: begin
          if (accept) begin
            word_cnt <= len_n;
            word_idx <= '0;
            lane     <= '0;
            xor_acc  <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            xor_acc <= xor_acc ^ in_data;
            if (lane == 2'd3) begin
              we       <= 1'b1;
              waddr    <= word_idx[ADDR_WIDTH-1:0];
              wdata    <= {in_data, shreg};
              word_idx <= word_idx + 1'b1;
              lane     <= 2'd0;
            end else begin
              shreg[{lane, 3'b000} +: 8] <= in_data;
              lane                       <= lane + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
